// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier (dtc) vote accumulator.
// Holds the tree output width, the FSM state type and the majority helper.
package dtc_pkg;

   localparam int unsigned DTC_CLASS_W   = 14;
   // Widest counter the majority helper accepts (WINDOW <= 255).
   localparam int unsigned DTC_MAX_CNT_W = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } dtc_state_e;

   // Strict majority: 2*cnt > n, evaluated one bit wider so 2*cnt cannot wrap.
   function automatic logic maj_bit(input logic [DTC_MAX_CNT_W-1:0] cnt,
                                    input logic [DTC_MAX_CNT_W-1:0] n);
      logic [DTC_MAX_CNT_W:0] twice;
      twice = {cnt, 1'b0};
      return twice > {1'b0, n};
   endfunction

endpackage

// File: rtl/dtc_bit_counter.sv
// Per-bit hit counter for one classifier output bit.
// cnt_upd is the value the counter takes at the next edge.
module dtc_bit_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_upd
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_upd = cnt_d;

endmodule

// File: rtl/dtc_vote_accum.sv
// Windowed strict-majority vote over per-sample classifier vectors.
// Accumulates up to WINDOW beats, then holds the registered result until taken.
module dtc_vote_accum
   import dtc_pkg::*;
#(
   parameter int unsigned WIDTH  = DTC_CLASS_W,
   parameter int unsigned WINDOW = 8,
   parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_vec,
   output logic [CNT_W-1:0] out_count
);

   dtc_state_e       state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [WIDTH-1:0] out_vec_q;
   logic [CNT_W-1:0] out_count_q;
   logic             accept;
   logic             clr;
   logic             close;
   logic [CNT_W-1:0] cnt_upd [WIDTH];
   logic [WIDTH-1:0] maj;

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;
   assign clr       = out_valid && out_ready;

   always_comb begin
      n_d = n_q + CNT_W'(accept);
      if (clr) begin
         n_d = '0;
      end
   end

   // In ACCUM n_q < WINDOW, so n_d != 0 is exactly "n > 0 or accepting now".
   assign close = in_ready &&
                  ((accept && (n_d == CNT_W'(WINDOW))) || (flush && (n_d != '0)));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dtc_bit_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc     (accept && in_vec[i]),
         .clr     (clr),
         .cnt_upd (cnt_upd[i])
      );
   end

   always_comb begin
      maj = '0;
      for (int i = 0; i < WIDTH; i++) begin
         maj[i] = maj_bit(DTC_MAX_CNT_W'(cnt_upd[i]), DTC_MAX_CNT_W'(n_d));
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: if (close) state_d = HOLD;
         HOLD:  if (clr)   state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         n_q         <= '0;
         out_vec_q   <= '0;
         out_count_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         if (close) begin
            out_vec_q   <= maj;
            out_count_q <= n_d;
         end
      end
   end

   assign out_vec   = out_vec_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Self-checking bench for dtc_vote_accum: window table, directed corner cases and
// randomized traffic against a queue-based window/majority model.
module tb_dtc_vote_accum;

   localparam int W   = 14;
   localparam int WIN = 8;
   localparam int CW  = $clog2(WIN + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_vec;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_vec;
   logic [CW-1:0] out_count;

   always #5 clk = ~clk;

   dtc_vote_accum #(
      .WIDTH  (W),
      .WINDOW (WIN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_count (out_count)
   );

   // Model: list of accepted vectors in the open window plus the last result.
   bit           m_hold;
   logic [W-1:0] m_win [$];
   logic [W-1:0] m_vec;
   int           m_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_close();
      int c;
      for (int b = 0; b < W; b++) begin
         c = 0;
         foreach (m_win[k]) if (m_win[k][b]) c++;
         m_vec[b] = (2 * c > m_win.size());
      end
      m_cnt  = m_win.size();
      m_hold = 1'b1;
   endfunction

   // One clock: drive, check outputs against model, advance the model, clock.
   task automatic step(input logic r, input logic v, input logic [W-1:0] vec,
                       input logic fl, input logic ordy);
      rst       = r;
      in_valid  = v;
      in_vec    = vec;
      flush     = fl;
      out_ready = ordy;
      #1;
      chk("in_ready",  {31'd0, in_ready},  {31'd0, !m_hold});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
      chk("out_vec",   32'(out_vec),       32'(m_vec));
      chk("out_count", 32'(out_count),     32'(m_cnt));
      if (r) begin
         m_hold = 1'b0;
         m_win.delete();
         m_vec  = '0;
         m_cnt  = 0;
      end else if (m_hold) begin
         if (ordy) begin
            m_hold = 1'b0;
            m_win.delete();
         end
      end else begin
         if (v) m_win.push_back(vec);
         if ((v && m_win.size() == WIN) || (fl && m_win.size() > 0)) model_close();
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [W-1:0] a;
      int           na;
      logic [W-1:0] b;
      int           nb;
      logic [W-1:0] exp_vec;
      int           exp_cnt;
   } win_t;

   win_t tbl [4];
   logic [W-1:0] held_vec;
   logic [CW-1:0] held_cnt;

   initial begin
      tbl[0] = '{14'b00000100000011, 8, 14'b0, 0, 14'b00000100000011, 8};
      tbl[1] = '{14'b10000100001000, 5, 14'b0, 3, 14'b10000100001000, 8};
      tbl[2] = '{14'b10000100001000, 4, 14'b0, 4, 14'b0,              8};
      tbl[3] = '{14'h3FFF,           3, 14'h0001, 5, 14'h0001,        8};

      rst = 1'b1; in_valid = 1'b0; in_vec = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_hold = 1'b0; m_vec = '0; m_cnt = 0; m_win.delete();
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);   // reset state checked inside

      // Window table: result one cycle after the last accept, then handshake.
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < tbl[t].na; k++) step(1'b0, 1'b1, tbl[t].a, 1'b0, 1'b1);
         for (int k = 0; k < tbl[t].nb; k++) step(1'b0, 1'b1, tbl[t].b, 1'b0, 1'b1);
         chk("tbl_valid", {31'd0, out_valid}, 32'd1);
         chk("tbl_vec",   32'(out_vec),       32'(tbl[t].exp_vec));
         chk("tbl_count", 32'(out_count),     32'(tbl[t].exp_cnt));
         step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      end

      // Backpressure: result stays put and no beats are consumed.
      for (int k = 0; k < WIN; k++) step(1'b0, 1'b1, 14'h1234, 1'b0, 1'b1);
      held_vec = out_vec;
      held_cnt = out_count;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_vec",      32'(out_vec),      32'(held_vec));
         chk("bp_count",    32'(out_count),    32'(held_cnt));
      end
      step(1'b0, 1'b1, 14'h0F0F, 1'b0, 1'b1);
      chk("bp_ready_after", {31'd0, in_ready}, 32'd1);

      // Flush with a same-cycle beat: 2/4 tie gives 0, count 4.
      step(1'b0, 1'b1, 14'b01000000010100, 1'b0, 1'b1);
      step(1'b0, 1'b1, 14'b01000000010100, 1'b0, 1'b1);
      step(1'b0, 1'b1, 14'b0,              1'b0, 1'b1);
      step(1'b0, 1'b1, 14'b0,              1'b1, 1'b0);
      chk("fl_valid", {31'd0, out_valid}, 32'd1);
      chk("fl_count", 32'(out_count),     32'd4);
      chk("fl_vec",   32'(out_vec),       32'd0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);   // flush in HOLD ignored
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);   // flush with empty window
      chk("fl_empty", {31'd0, out_valid}, 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Reset mid-window discards partial counts.
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 14'b00000000001100, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < WIN; k++) step(1'b0, 1'b1, 14'b0, 1'b0, 1'b1);
      chk("rst_vec",   32'(out_vec),   32'd0);
      chk("rst_count", 32'(out_count), 32'd8);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Gapped input with garbage on idle beats.
      for (int k = 0; k < 2 * WIN - 1; k++) begin
         if (k % 2 == 0) step(1'b0, 1'b1, 14'h3FFF, 1'b0, 1'b1);
         else            step(1'b0, 1'b0, W'($urandom), 1'b0, 1'b1);
      end
      chk("gap_valid", {31'd0, out_valid}, 32'd1);
      chk("gap_vec",   32'(out_vec),       32'h3FFF);
      chk("gap_count", 32'(out_count),     32'd8);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) != 0),
              W'($urandom),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 9) < 7));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
